// File: rtl/led_bus_initiator.sv
// Bus initiator for the switch/LED peripheral: on a trigger it reads the switch register,
// steps the LED index and writes it back. Define INIT_POLL_EN to add a periodic poll trigger.
module led_bus_initiator #(
    parameter logic [7:0]  SW_ADDR      = 8'h04,
    parameter logic [7:0]  LED_ADDR     = 8'h00,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_PERIOD  = 50000
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        fabint,
    input  logic [31:0] bus_read_data,
    output logic        bus_write_en,
    output logic        bus_read_en,
    output logic [7:0]  bus_addr,
    output logic [31:0] bus_write_data,
    output logic [2:0]  led_index,
    output logic        busy,
    output logic [7:0]  drop_count
);
    localparam int unsigned LAT_W = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        CALC = 3'd3,
        WR   = 3'd4
    } state_t;

    state_t           state;
    logic             fabint_q;
    logic             pend;
    logic [LAT_W-1:0] lat_cnt;
    logic [1:0]       sw_code;
    logic [2:0]       new_idx;
    logic             fab_edge;
    logic             poll_hit;
    logic             trigger;
    logic             start;
    logic             unused_rd_bits;

    assign unused_rd_bits = ^bus_read_data[31:2];

    assign fab_edge = fabint & ~fabint_q;
    assign trigger  = fab_edge | poll_hit;
    assign start    = (state == IDLE) && (trigger || pend);

`ifdef INIT_POLL_EN
    localparam int unsigned POLL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    logic [POLL_W-1:0] poll_cnt;

    assign poll_hit = (poll_cnt == POLL_W'(POLL_PERIOD - 1));

    // Free-running poll timer, re-aligned whenever a transaction starts
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            poll_cnt <= '0;
        end else if (poll_hit || start) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + POLL_W'(1);
        end
    end
`else
    localparam int unsigned unused_poll_period = POLL_PERIOD;

    assign poll_hit = 1'b0;
`endif

    // Next LED index from the sampled switch code (modulo-8 wrap is natural)
    always_comb begin
        new_idx = led_index;
        case (sw_code)
            2'b01:   new_idx = led_index + 3'd1;
            2'b10:   new_idx = led_index - 3'd1;
            2'b11:   new_idx = 3'd0;
            default: new_idx = led_index;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state          <= IDLE;
            fabint_q       <= 1'b0;
            pend           <= 1'b0;
            lat_cnt        <= '0;
            sw_code        <= 2'b00;
            bus_write_en   <= 1'b0;
            bus_read_en    <= 1'b0;
            bus_addr       <= 8'h00;
            bus_write_data <= 32'h0;
            led_index      <= 3'd0;
            busy           <= 1'b0;
            drop_count     <= 8'h00;
        end else begin
            fabint_q     <= fabint;
            bus_read_en  <= 1'b0;
            bus_write_en <= 1'b0;

            // One-deep pend; further triggers while it is held are counted as lost
            if (trigger && (state != IDLE)) begin
                if (!pend) begin
                    pend <= 1'b1;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        pend        <= 1'b0;
                        state       <= RD;
                        busy        <= 1'b1;
                        bus_read_en <= 1'b1;
                        bus_addr    <= SW_ADDR;
                    end
                end
                RD: begin
                    state   <= WAIT;
                    lat_cnt <= LAT_W'(READ_LATENCY);
                end
                WAIT: begin
                    if (lat_cnt <= LAT_W'(1)) begin
                        sw_code <= bus_read_data[1:0];
                        state   <= CALC;
                    end
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end
                CALC: begin
                    if (sw_code == 2'b00) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state          <= WR;
                        bus_write_en   <= 1'b1;
                        bus_addr       <= LED_ADDR;
                        bus_write_data <= {29'd0, new_idx};
                    end
                end
                WR: begin
                    led_index <= bus_write_data[2:0];
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_bus_initiator.sv
// Scoreboard bench for led_bus_initiator: expected LED writes are queued at stimulus time
// and compared when the write strobe appears; a second instance covers READ_LATENCY=3.
`timescale 1ns/1ps
module tb_led_bus_initiator;
    logic        clk;
    logic        nreset;
    logic        fabint;
    logic [31:0] rd_data;
    logic        wr_en, rd_en, busy;
    logic [7:0]  addr, drops;
    logic [31:0] wdata;
    logic [2:0]  led;

    logic        fabint3;
    logic [31:0] rd_data3;
    logic        wr_en3, rd_en3, busy3;
    logic [7:0]  addr3, drops3;
    logic [31:0] wdata3;
    logic [2:0]  led3;

    int          n_asserts = 0;
    int          n_fails   = 0;
    int          n_writes  = 0;
    int unsigned cyc       = 0;
    logic [31:0] exp_q[$];
    logic [2:0]  model_idx;

    led_bus_initiator #(.READ_LATENCY(1)) u_dut (
        .clk(clk), .nreset(nreset), .fabint(fabint), .bus_read_data(rd_data),
        .bus_write_en(wr_en), .bus_read_en(rd_en), .bus_addr(addr),
        .bus_write_data(wdata), .led_index(led), .busy(busy), .drop_count(drops)
    );

    led_bus_initiator #(.READ_LATENCY(3)) u_lat3 (
        .clk(clk), .nreset(nreset), .fabint(fabint3), .bus_read_data(rd_data3),
        .bus_write_en(wr_en3), .bus_read_en(rd_en3), .bus_addr(addr3),
        .bus_write_data(wdata3), .led_index(led3), .busy(busy3), .drop_count(drops3)
    );

`ifdef INIT_POLL_EN
    logic        p_fab;
    logic [31:0] p_data;
    logic        p_wr_en, p_rd_en, p_busy;
    logic [7:0]  p_addr, p_drops;
    logic [31:0] p_wdata;
    logic [2:0]  p_led;

    led_bus_initiator #(.READ_LATENCY(1), .POLL_PERIOD(16)) u_poll (
        .clk(clk), .nreset(nreset), .fabint(p_fab), .bus_read_data(p_data),
        .bus_write_en(p_wr_en), .bus_read_en(p_rd_en), .bus_addr(p_addr),
        .bus_write_data(p_wdata), .led_index(p_led), .busy(p_busy), .drop_count(p_drops)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic [1:0] code);
        case (code)
            2'b01:   return (idx == 3'd7) ? 3'd0 : idx + 3'd1;
            2'b10:   return (idx == 3'd0) ? 3'd7 : idx - 3'd1;
            2'b11:   return 3'd0;
            default: return idx;
        endcase
    endfunction

    // Scoreboard side: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (nreset) begin
            check("strobe_overlap", 32'(wr_en & rd_en), 32'd0);
            if (wr_en) begin
                n_writes++;
                check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("wr_data", wdata, exp_q.pop_front());
                    check("wr_addr", 32'(addr), 32'h00);
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_code(input logic [1:0] code);
        rd_data = {30'($urandom), code};
        model_idx = next_idx(model_idx, code);
        if (code != 2'b00) exp_q.push_back({29'd0, model_idx});
        fabint = 1'b1;
        @(negedge clk);
        fabint = 1'b0;
        wait_idle();
        @(negedge clk);
        check("led_index", 32'(led), 32'(model_idx));
    endtask

    initial begin
        logic [1:0]  seq [7];
        int          bc, w0, n, k, wr_k;
        logic [31:0] wr_d;
        logic        strobes;

        seq = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11};
        nreset = 1'b0; fabint = 1'b0; rd_data = 32'h0;
        fabint3 = 1'b0; rd_data3 = 32'h0;
`ifdef INIT_POLL_EN
        p_fab = 1'b0; p_data = 32'h0;
`endif
        model_idx = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, wr_en, rd_en, led, addr}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_drops", 32'(drops), 32'd0);
        nreset = 1'b1;
        @(negedge clk);

        // First transaction with explicit trigger-to-strobe latency
        rd_data = 32'h0000_0001;
        model_idx = 3'd1;
        exp_q.push_back(32'd1);
        fabint = 1'b1;
        @(negedge clk);
        fabint = 1'b0;
        check("rd_en_cycle1", 32'(rd_en), 32'd1);
        check("rd_addr", 32'(addr), 32'h04);
        check("busy_cycle1", 32'(busy), 32'd1);
        @(negedge clk);
        check("rd_en_single", 32'(rd_en), 32'd0);
        @(negedge clk);
        check("wr_en_calc", 32'(wr_en), 32'd0);
        @(negedge clk);
        check("wr_en_cycle4", 32'(wr_en), 32'd1);
        @(negedge clk);
        check("busy_after_wr", 32'(busy), 32'd0);
        check("led_first", 32'(led), 32'd1);

        // Wraps in both directions, then clear from index 5
        for (int i = 0; i < 7; i++) run_code(seq[i]);

        // Spurious read: no write, busy for RD/WAIT/CALC only
        w0 = n_writes;
        rd_data = 32'hFFFF_FFFC;
        fabint = 1'b1;
        @(negedge clk);
        fabint = 1'b0;
        bc = 0;
        while (busy && bc < 20) begin
            bc++;
            @(negedge clk);
        end
        check("busy_cycles_spurious", 32'(bc), 32'd3);
        check("no_write_spurious", 32'(n_writes - w0), 32'd0);
        check("led_spurious", 32'(led), 32'(model_idx));

        // Three pulses in one transaction: one pend, one drop, one follow-on
        w0 = n_writes;
        rd_data = 32'h8000_0001;
        model_idx = next_idx(model_idx, 2'b01);
        exp_q.push_back({29'd0, model_idx});
        model_idx = next_idx(model_idx, 2'b01);
        exp_q.push_back({29'd0, model_idx});
        for (int p = 0; p < 3; p++) begin
            fabint = 1'b1;
            @(negedge clk);
            fabint = 1'b0;
            @(negedge clk);
        end
        n = 0;
        while (((n_writes - w0) < 2 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("follow_on_writes", 32'(n_writes - w0), 32'd2);
        check("drop_count", 32'(drops), 32'd1);
        check("led_follow_on", 32'(led), 32'(model_idx));

        // Reset asserted in WAIT aborts the transaction
        rd_data = 32'h1;
        fabint = 1'b1;
        @(negedge clk);
        fabint = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        #1;
        check("midrst_outputs", {busy, wr_en, rd_en, led, addr}, 32'd0);
        check("midrst_wdata", wdata, 32'd0);
        check("midrst_drops", 32'(drops), 32'd0);
        model_idx = 3'd0;
        @(negedge clk);
        nreset = 1'b1;
        strobes = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            strobes = strobes | wr_en | rd_en;
        end
        check("no_strobe_after_rst", 32'(strobes), 32'd0);
        check("led_after_rst", 32'(led), 32'd0);

        // READ_LATENCY=3: only the value present at the third edge after the read counts
        rd_data3 = 32'h3;
        fabint3 = 1'b1;
        @(negedge clk);
        fabint3 = 1'b0;
        check("l3_rd_en", 32'(rd_en3), 32'd1);
        wr_k = -1;
        wr_d = 32'hFFFF_FFFF;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 3) rd_data3 = 32'h1;
            if (k == 4) rd_data3 = 32'h2;
            if (wr_en3) begin
                wr_k = k;
                wr_d = wdata3;
            end
        end while (busy3 && k < 30);
        check("l3_wdata", wr_d, 32'd1);
        check("l3_wr_cycle", 32'(wr_k), 32'd5);
        check("l3_led", 32'(led3), 32'd1);

`ifdef INIT_POLL_EN
        begin
            int unsigned t0, t1;
            for (int r = 0; r < 2; r++) begin
                n = 0;
                while (!p_rd_en && n < 100) begin @(negedge clk); n++; end
                t0 = cyc;
                @(negedge clk);
                n = 0;
                while (!p_rd_en && n < 100) begin @(negedge clk); n++; end
                t1 = cyc;
                check("poll_period", t1 - t0, 32'd16);
            end
        end
`endif

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
